// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, then shift a byte,
// odd parity and stop bit out on device-generated clocks and check the ACK.
module ps2_tx #(
  parameter int unsigned INHIBIT_CYC = 1600,
  parameter int unsigned TIMEOUT_CYC = 320000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       timeout,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned MAX_CYC = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_SEND      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       fe_cnt_q, fe_cnt_d;
  logic [9:0]       shift_q, shift_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             nack_q, nack_d;
  logic             timeout_q, timeout_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;
  logic fe_c;
  logic tmo_hit_c;

  // Pin synchronizers; idle-high reset value avoids a spurious edge after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_i;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat_i;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fe_c      = clk_prev_q & ~clk_s2_q;
  assign tmo_hit_c = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      fe_cnt_q  <= '0;
      shift_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
      timeout_q <= 1'b0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fe_cnt_q  <= fe_cnt_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      nack_q    <= nack_d;
      timeout_q <= timeout_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
    end
  end

  // Next-state logic; shift_q holds {stop, parity, D7..D0} still to be presented
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fe_cnt_d  = fe_cnt_q;
    shift_d   = shift_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    nack_d    = nack_q;
    timeout_d = timeout_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;

    case (state_q)
      S_IDLE: begin
        busy_d   = 1'b0;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_start && !busy_q) begin
          state_d   = S_INHIBIT;
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
          nack_d    = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          fe_cnt_d  = '0;
          shift_d   = {1'b1, ~^tx_data, tx_data};
        end
      end

      S_INHIBIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(INHIBIT_CYC - 1)) begin
          state_d  = S_REQ;
          dat_oe_d = 1'b1;
        end
      end

      S_REQ: begin
        state_d  = S_SEND;
        clk_oe_d = 1'b0;
        cnt_d    = '0;
      end

      S_SEND: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tmo_hit_c) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          dat_oe_d  = 1'b0;
        end else if (fe_c) begin
          fe_cnt_d = fe_cnt_q + 4'd1;
          if (fe_cnt_q == 4'd10) begin
            nack_d   = dat_s2_q;
            dat_oe_d = 1'b0;
            state_d  = S_WAIT_IDLE;
          end else begin
            dat_oe_d = ~shift_q[0];
            shift_d  = {1'b1, shift_q[9:1]};
          end
        end
      end

      S_WAIT_IDLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tmo_hit_c) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          done_d    = 1'b1;
        end else if (clk_s2_q && dat_s2_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d  = S_IDLE;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
      end
    endcase
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign nack       = nack_q;
  assign timeout    = timeout_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: doc/ps2_tx.md
# ps2_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the 6502 bus interface to the attached keyboard over the shared open-drain ps2_clk/ps2_dat pins. It runs the inhibit/request-to-send sequence, shifts out data, parity and stop bits on device-generated clocks, then checks the device ACK. It sits beside the PS/2 receiver in tst_6502; its `busy` gates the receiver.

## Interface
Parameters:
- INHIBIT_CYC, 1600: cycles clock is held low before request-to-send (100 µs at 16 MHz).
- TIMEOUT_CYC, 320000: max cycles from clock release to ACK (20 ms at 16 MHz).

Ports:
- clk  in  1  system clock, 16 MHz.
- reset  in  1  synchronous, active-high.
- tx_data  in  8  byte to send; latched on accepted tx_start.
- tx_start  in  1  one-cycle request; accepted only when busy=0.
- busy  out  1  high from cycle after accepted start until done cycle inclusive.
- done  out  1  one-cycle pulse at end of every transfer (success or failure).
- nack  out  1  status valid with done: device did not ACK; held until next accepted start.
- timeout  out  1  status valid with done: TIMEOUT_CYC expired; held until next accepted start.
- ps2_clk_i  in  1  raw clock pin input (asynchronous).
- ps2_dat_i  in  1  raw data pin input (asynchronous).
- ps2_clk_oe  out  1  1 = drive clock pin low; 0 = release.
- ps2_dat_oe  out  1  1 = drive data pin low; 0 = release.

## Operation
- Inputs pass 2-FF synchronizers; falling edge of clock = sync'd previous 1, current 0 (fe pulse).
- Frame bits: start 0, D0..D7 LSB first, parity = ~^tx_data (odd), stop 1. ps2_dat_oe = ~current bit.
- States:
  - IDLE: both oe=0, busy=0. tx_start → INHIBIT, latch byte, clear nack/timeout, clear counters.
  - INHIBIT: clk_oe=1, dat_oe=0, count INHIBIT_CYC cycles → REQ.
  - REQ: clk_oe=1, dat_oe=1 (start bit), one cycle → SEND.
  - SEND: clk_oe=0; bit index 0..10. Each fe advances index: fe 1–8 present D0–D7, fe 9 parity, fe 10 stop (dat_oe=0). fe 11 → sample data: 0 = ACK, 1 = nack; → WAIT_IDLE.
  - WAIT_IDLE: oe=0; when sync'd clock and data both 1 → done, → IDLE.
- Timeout counter runs in SEND and WAIT_IDLE; reaching TIMEOUT_CYC → timeout=1, oe=0, done, → IDLE (overrides pending edge same cycle).
- nack and ACK-success both finish via WAIT_IDLE; nack=1 does not abort early.
- tx_start while busy ignored; no queueing.
- Reset (any state): next cycle IDLE, oe=0, busy=0, done=0, nack=0, timeout=0, counters 0, synchronizers to 1.

## Timing
- tx_start at cycle N → busy=1, clk_oe=1 at N+1.
- clk_oe asserted exactly INHIBIT_CYC+1 cycles; dat_oe rises on last of those cycles; clk_oe falls with dat_oe still 1.
- Pin falling edge → fe 3 cycles later (2 sync + 1 detect) → dat_oe update next cycle (≤4 cycles total, ≪ 40 µs half-period).
- done asserts the cycle after both lines observed high in WAIT_IDLE; busy drops the cycle after done.
- Counters sized for parameters: clog2(TIMEOUT_CYC+1) bits; no wrap permitted.

## Test plan
- Device BFM (80 µs clock, samples data on rising edge, ACKs) with tx_data=0xED → received bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulse, nack=0, timeout=0; clk_oe low time = 1601 cycles.
- tx_data=0x01 and 0xFF → parity 0 and 1 respectively; 0x00 → parity 1; all ACKed, done once each.
- BFM withholds ACK (data high on clock 11) → done with nack=1, timeout=0; lines released; busy low after done.
- BFM never clocks → timeout=1 with done exactly TIMEOUT_CYC cycles after clk_oe release; oe=0.
- tx_start pulsed again during SEND → ignored; byte on wire unchanged; single done.
- reset asserted mid-SEND (after fe 4) → next cycle both oe=0, busy=0, no done; subsequent 0xF4 transfer completes normally.
